// File: rtl/ppu_pkg.sv
// ppu_pkg: shared constants and types for the PPU VRAM arbiter
package ppu_pkg;
  localparam int PPU_ADDR_W   = 14;
  localparam int PPU_DATA_W   = 8;
  localparam int PPU_MAX_WAIT = 16;
  typedef enum logic [1:0] {IDLE, REN, CPU} ppu_owner_t;
  typedef struct packed {
    logic                  we;
    logic [PPU_ADDR_W-1:0] addr;
    logic [PPU_DATA_W-1:0] wdata;
  } ppu_cpu_req_t;
endpackage

// File: rtl/ppu_cpu_req_slot.sv
// ppu_cpu_req_slot: one-entry CPU access holder with a saturating starvation wait counter
module ppu_cpu_req_slot
  import ppu_pkg::*;
#(
  parameter int MAX_WAIT = PPU_MAX_WAIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_i,
  input  ppu_cpu_req_t req_data_i,
  input  logic         issue_i,
  output logic         full_o,
  output logic         force_o,
  output ppu_cpu_req_t slot_o
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic          full_q, full_d, fill;
  logic [WW-1:0] wait_q, wait_d;
  ppu_cpu_req_t  slot_q, slot_d;
  assign fill = req_i && !full_q;
  always_comb begin
    full_d = issue_i ? 1'b0 : (full_q || fill);
    slot_d = fill ? req_data_i : slot_q;
    wait_d = (issue_i || fill) ? '0 :
             (full_q && wait_q != WW'(MAX_WAIT)) ? wait_q + 1'b1 : wait_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      wait_q <= '0;
      slot_q <= '0;
    end else begin
      full_q <= full_d;
      wait_q <= wait_d;
      slot_q <= slot_d;
    end
  end
  assign full_o  = full_q;
  assign force_o = full_q && wait_q >= WW'(MAX_WAIT);
  assign slot_o  = slot_q;
endmodule

// File: rtl/ppu_vram_arbiter.sv
// ppu_vram_arbiter: shares the VRAM bus between render fetches (priority) and a
// one-entry CPU slot; owner_q remembers who owns the RETURN stage.
module ppu_vram_arbiter
  import ppu_pkg::*;
#(
  parameter int ADDR_W   = PPU_ADDR_W,
  parameter int DATA_W   = PPU_DATA_W,
  parameter int MAX_WAIT = PPU_MAX_WAIT
) (
  input  logic              PPU_SLOW_CLOCK,
  input  logic              RST,
  input  logic              REN_REQ,
  input  logic [ADDR_W-1:0] REN_ADDR,
  output logic              REN_GNT,
  output logic              REN_VALID,
  output logic [DATA_W-1:0] REN_RDATA,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
  output logic              CPU_BUSY,
  output logic              CPU_DONE,
  output logic [DATA_W-1:0] CPU_RDATA,
  output logic [ADDR_W-1:0] APPU,
  output logic              ALE,
  output logic              VRAM_WE,
  output logic [DATA_W-1:0] PPUDO,
  input  logic [DATA_W-1:0] PPUDI
);
  ppu_owner_t        owner_q, owner_d;
  ppu_cpu_req_t      cpu_req, slot;
  logic              slot_full, slot_force, cpu_issue, ret_we_q;
  logic [ADDR_W-1:0] appu_q;
  logic [DATA_W-1:0] ren_rdata_q, cpu_rdata_q;
  assign cpu_req = '{we: CPU_WE, addr: PPU_ADDR_W'(CPU_ADDR), wdata: PPU_DATA_W'(CPU_WDATA)};
  ppu_cpu_req_slot #(.MAX_WAIT(MAX_WAIT)) u_slot (
    .clk       (PPU_SLOW_CLOCK),
    .rst       (RST),
    .req_i     (CPU_REQ),
    .req_data_i(cpu_req),
    .issue_i   (cpu_issue),
    .full_o    (slot_full),
    .force_o   (slot_force),
    .slot_o    (slot)
  );
  always_comb begin
    owner_d   = RST ? IDLE : slot_force ? CPU : REN_REQ ? REN : slot_full ? CPU : IDLE;
    cpu_issue = owner_d == CPU;
    REN_GNT   = owner_d == REN;
    ALE       = owner_d != IDLE;
    VRAM_WE   = cpu_issue && slot.we;
    PPUDO     = VRAM_WE ? DATA_W'(slot.wdata) : '0;
    APPU      = cpu_issue ? ADDR_W'(slot.addr) : REN_GNT ? REN_ADDR : appu_q;
    // RST in the RETURN cycle discards the in-flight access
    REN_VALID = !RST && owner_q == REN;
    CPU_DONE  = !RST && owner_q == CPU;
    CPU_BUSY  = !RST && (slot_full || owner_q == CPU);
    REN_RDATA = REN_VALID ? PPUDI : ren_rdata_q;
    CPU_RDATA = (CPU_DONE && !ret_we_q) ? PPUDI : cpu_rdata_q;
  end
  always_ff @(posedge PPU_SLOW_CLOCK) begin
    if (RST) begin
      owner_q     <= IDLE;
      appu_q      <= '0;
      ret_we_q    <= 1'b0;
      ren_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      owner_q     <= owner_d;
      appu_q      <= APPU;
      ret_we_q    <= VRAM_WE;
      ren_rdata_q <= REN_RDATA;
      cpu_rdata_q <= CPU_RDATA;
    end
  end
endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// tb_ppu_vram_arbiter: directed + random stimulus, reference model feeds scoreboard queues
module tb_ppu_vram_arbiter;
  localparam int MAX_WAIT = 16;
  logic        clk = 0;
  logic        RST, REN_REQ, CPU_REQ, CPU_WE;
  logic [13:0] REN_ADDR, CPU_ADDR, APPU;
  logic [7:0]  CPU_WDATA, PPUDI, PPUDO, REN_RDATA, CPU_RDATA;
  logic        REN_GNT, REN_VALID, CPU_BUSY, CPU_DONE, ALE, VRAM_WE;

  ppu_vram_arbiter #(.ADDR_W(14), .DATA_W(8), .MAX_WAIT(MAX_WAIT)) dut (
    .PPU_SLOW_CLOCK(clk), .RST(RST),
    .REN_REQ(REN_REQ), .REN_ADDR(REN_ADDR), .REN_GNT(REN_GNT),
    .REN_VALID(REN_VALID), .REN_RDATA(REN_RDATA),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_BUSY(CPU_BUSY), .CPU_DONE(CPU_DONE), .CPU_RDATA(CPU_RDATA),
    .APPU(APPU), .ALE(ALE), .VRAM_WE(VRAM_WE), .PPUDO(PPUDO), .PPUDI(PPUDI)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; bit is_ren; logic [13:0] addr; bit we; logic [7:0] wd;} bus_t;
  typedef struct {int cyc; logic [7:0] d;} ret_t;
  bus_t busq[$];
  ret_t renq[$];
  ret_t cpuq[$];
  bit          exp_busy[0:2047];
  logic [13:0] exp_hold[0:2047];
  int cyc = 0, n_chk = 0, n_fail = 0;
  bit prev_rst = 1;
  logic [7:0] pdi_next = 0;

  // reference model state: what the arbitration rules say the slot holds
  bit          m_full, m_we, m_prev_cpu, ren_hold;
  int          m_wait;
  logic [13:0] m_addr, m_last, ren_addr;
  logic [7:0]  m_wdata, m_rd;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    PPUDI = pdi_next;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model(input bit rst, input bit ren, input bit creq, input bit we,
                       input logic [13:0] ca, input logic [7:0] cd);
    bit iss_cpu, gnt;
    exp_busy[cyc] = !rst && (m_full || m_prev_cpu);
    exp_hold[cyc] = m_last;
    iss_cpu = !rst && m_full && (m_wait >= MAX_WAIT || !ren);
    gnt = !rst && ren && !iss_cpu;
    if (rst) begin
      while (renq.size() > 0 && renq[$].cyc == cyc) void'(renq.pop_back());
      while (cpuq.size() > 0 && cpuq[$].cyc == cyc) void'(cpuq.pop_back());
      m_full = 0; m_wait = 0; m_prev_cpu = 0; m_last = 0; m_rd = 0;
      ren_hold = ren;
    end else begin
      if (gnt) begin
        busq.push_back('{cyc, 1'b1, ren_addr, 1'b0, 8'h00});
        renq.push_back('{cyc + 1, ren_addr[7:0]});
        m_last = ren_addr;
        ren_addr = ren_addr + 14'd1;
      end
      if (iss_cpu) begin
        busq.push_back('{cyc, 1'b0, m_addr, m_we, m_wdata});
        cpuq.push_back('{cyc + 1, m_we ? m_rd : m_addr[7:0]});
        if (!m_we) m_rd = m_addr[7:0];
        m_last = m_addr;
      end
      m_prev_cpu = iss_cpu;
      ren_hold = ren && !gnt;
      if (iss_cpu) begin
        m_full = 0; m_wait = 0;
      end else if (m_full) begin
        if (m_wait < MAX_WAIT) m_wait++;
      end else if (creq) begin
        m_full = 1; m_wait = 0; m_we = we; m_addr = ca; m_wdata = cd;
      end
    end
  endtask

  task automatic step(input bit rst, input bit ren, input bit creq, input bit we,
                      input logic [13:0] ca, input logic [7:0] cd);
    bit r;
    r = ren | ren_hold;
    RST = rst; REN_REQ = r; REN_ADDR = ren_addr;
    CPU_REQ = creq; CPU_WE = we; CPU_ADDR = ca; CPU_WDATA = cd;
    model(rst, r, creq, we, ca, cd);
    @(posedge clk);
    #1;
  endtask

  // monitor: compares DUT outputs mid-cycle against the scoreboard queues
  always @(negedge clk) begin
    bus_t b;
    ret_t r;
    if (cyc >= 1) begin
      if (RST) begin
        chk("rst_ctrl", {REN_GNT, REN_VALID, CPU_BUSY, CPU_DONE, ALE, VRAM_WE}, 0);
        if (prev_rst) chk("rst_regs", {APPU, PPUDO, REN_RDATA, CPU_RDATA}, 0);
      end else begin
        if (ALE) begin
          if (busq.size() == 0) chk("bus_extra", 1, 0);
          else begin
            b = busq.pop_front();
            chk("bus_cyc", cyc, b.cyc);
            chk("bus_addr", APPU, b.addr);
            chk("bus_we", VRAM_WE, b.we);
            chk("bus_wdata", PPUDO, b.we ? b.wd : 8'h00);
            chk("ren_gnt", REN_GNT, b.is_ren);
          end
        end else begin
          chk("idle_ctrl", {REN_GNT, VRAM_WE}, 0);
          chk("idle_appu", APPU, exp_hold[cyc]);
        end
        if (REN_VALID) begin
          if (renq.size() == 0) chk("ren_valid_extra", 1, 0);
          else begin
            r = renq.pop_front();
            chk("ren_cyc", cyc, r.cyc);
            chk("ren_rdata", REN_RDATA, r.d);
          end
        end
        if (CPU_DONE) begin
          if (cpuq.size() == 0) chk("cpu_done_extra", 1, 0);
          else begin
            r = cpuq.pop_front();
            chk("cpu_cyc", cyc, r.cyc);
            chk("cpu_rdata", CPU_RDATA, r.d);
          end
        end
        chk("cpu_busy", CPU_BUSY, exp_busy[cyc]);
      end
      pdi_next = (!RST && ALE && !VRAM_WE) ? APPU[7:0] : 8'($urandom);
    end
    prev_rst = RST;
  end

  initial begin
    RST = 1; REN_REQ = 0; REN_ADDR = 0; CPU_REQ = 0; CPU_WE = 0; CPU_ADDR = 0; CPU_WDATA = 0;
    PPUDI = 0;
    m_full = 0; m_we = 0; m_prev_cpu = 0; ren_hold = 0; m_wait = 0;
    m_addr = 0; m_last = 0; m_wdata = 0; m_rd = 0; ren_addr = 14'h1000;
    @(posedge clk);
    #1;
    repeat (2) step(1, 1, 1, 0, 14'h3FFF, 8'hFF);
    repeat (8) step(0, 1, 0, 0, 14'h0, 8'h0);
    repeat (2) step(0, 0, 0, 0, 14'h0, 8'h0);
    step(0, 0, 1, 1, 14'h2005, 8'hA5);
    repeat (3) step(0, 0, 0, 0, 14'h0, 8'h0);
    ren_addr = 14'h0300;
    step(0, 1, 1, 0, 14'h23C0, 8'h00);
    step(0, 1, 1, 1, 14'h2000, 8'h11);
    repeat (3) step(0, 1, 0, 0, 14'h0, 8'h0);
    repeat (4) step(0, 0, 0, 0, 14'h0, 8'h0);
    ren_addr = 14'h0800;
    step(0, 1, 1, 0, 14'h0010, 8'h00);
    for (int i = 1; i <= 40; i++)
      step(0, 1, i == 17 || i == 18, i == 17, i == 17 ? 14'h2100 : 14'h2101, 8'h22);
    repeat (3) step(0, 0, 0, 0, 14'h0, 8'h0);
    ren_addr = 14'($urandom);
    for (int i = 0; i < 300; i++)
      step($urandom_range(99) < 2, $urandom_range(9) < 7, $urandom_range(4) == 0,
           1'($urandom), 14'($urandom), 8'($urandom));
    repeat (25) step(0, 0, 0, 0, 14'h0, 8'h0);
    chk("busq_drained", busq.size(), 0);
    chk("renq_drained", renq.size(), 0);
    chk("cpuq_drained", cpuq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
